// File: rtl/pdm_multi.sv
// Multi-channel pulse-density modulator with double-buffered levels and control.
// Each channel runs first-order (carry-out) or second-order (error-feedback) modulation.
module pdm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DIV      = 1,
  localparam int AW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                ctrl_wr,
  input  logic [CHANNELS-1:0] ctrl_en,
  input  logic [CHANNELS-1:0] ctrl_order2,
  input  logic                commit,
  output logic                step,
  output logic [CHANNELS-1:0] pdm_out
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam int SW = WIDTH + 4;
  localparam logic signed [SW-1:0] HALF = SW'(1 << (WIDTH - 1));
  localparam logic signed [SW-1:0] FULL = SW'(1 << WIDTH);
  localparam logic signed [SW-1:0] EMAX = SW'((1 << WIDTH) - 1);
  localparam logic signed [SW-1:0] EMIN = SW'(-(1 << WIDTH));

  logic [CW-1:0]             r_cnt;
  logic                      r_step;
  logic                      w_stepI;

  logic [WIDTH-1:0]          r_levelSh [CHANNELS];
  logic [WIDTH-1:0]          r_level   [CHANNELS];
  logic [CHANNELS-1:0]       r_enSh;
  logic [CHANNELS-1:0]       r_ordSh;
  logic [CHANNELS-1:0]       r_en;
  logic [CHANNELS-1:0]       r_ord;
  logic [CHANNELS-1:0]       r_pdm;

  logic [WIDTH-1:0]          r_acc [CHANNELS];
  logic signed [SW-1:0]      r_e1  [CHANNELS];
  logic signed [SW-1:0]      r_e2  [CHANNELS];

  logic [WIDTH-1:0]          w_levelShNext [CHANNELS];
  logic [CHANNELS-1:0]       w_enNext;
  logic [CHANNELS-1:0]       w_ordNext;
  logic [WIDTH:0]            w_sum  [CHANNELS];
  logic signed [SW-1:0]      w_v    [CHANNELS];
  logic signed [SW-1:0]      w_eRaw [CHANNELS];
  logic signed [SW-1:0]      w_e    [CHANNELS];
  logic [CHANNELS-1:0]       w_y;

  assign w_stepI = (r_cnt == CNT_MAX);
  assign step    = r_step;
  assign pdm_out = r_pdm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else begin
      r_cnt  <= w_stepI ? '0 : r_cnt + CW'(1);
      r_step <= w_stepI;
    end
  end

  // Shadow values as they will stand after this edge; commit copies these so a
  // same-cycle write reaches the active set. Out-of-range addresses match no channel.
  always_comb begin
    w_enNext  = ctrl_wr ? ctrl_en : r_enSh;
    w_ordNext = ctrl_wr ? ctrl_order2 : r_ordSh;
    for (int c = 0; c < CHANNELS; c++) begin
      w_levelShNext[c] = (wr_en && (wr_addr == AW'(c))) ? wr_data : r_levelSh[c];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_levelSh[c] <= '0;
        r_level[c]   <= '0;
      end
      r_enSh  <= '0;
      r_ordSh <= '0;
      r_en    <= '0;
      r_ord   <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_levelSh[c] <= w_levelShNext[c];
      end
      r_enSh  <= w_enNext;
      r_ordSh <= w_ordNext;
      if (commit) begin
        for (int c = 0; c < CHANNELS; c++) begin
          r_level[c] <= w_levelShNext[c];
        end
        r_en  <= w_enNext;
        r_ord <= w_ordNext;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_sum[c]  = {1'b0, r_level[c]} + {1'b0, r_acc[c]};
      w_v[c]    = $signed({4'b0000, r_level[c]}) + (r_e1[c] <<< 1) - r_e2[c];
      w_y[c]    = (w_v[c] >= HALF);
      w_eRaw[c] = w_y[c] ? (w_v[c] - FULL) : w_v[c];
      if (w_eRaw[c] > EMAX) begin
        w_e[c] = EMAX;
      end else if (w_eRaw[c] < EMIN) begin
        w_e[c] = EMIN;
      end else begin
        w_e[c] = w_eRaw[c];
      end
    end
  end

  // A mode change at commit overrides the step update so the new mode starts cold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c] <= '0;
        r_e1[c]  <= '0;
        r_e2[c]  <= '0;
      end
      r_pdm <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (!r_en[c]) begin
          r_acc[c] <= '0;
          r_e1[c]  <= '0;
          r_e2[c]  <= '0;
          r_pdm[c] <= 1'b0;
        end else begin
          if (w_stepI) begin
            if (r_ord[c]) begin
              r_pdm[c] <= w_y[c];
              r_e2[c]  <= r_e1[c];
              r_e1[c]  <= w_e[c];
            end else begin
              r_pdm[c] <= w_sum[c][WIDTH];
              r_acc[c] <= w_sum[c][WIDTH-1:0];
            end
          end
          if (commit && (w_ordNext[c] != r_ord[c])) begin
            r_acc[c] <= '0;
            r_e1[c]  <= '0;
            r_e2[c]  <= '0;
          end
        end
      end
    end
  end

endmodule

// File: doc/pdm_multi.md
Name: pdm_multi

Overview:
- Multi-channel, parametrised pulse-density modulator; successor to the single-channel 5-bit first-order PDM.
- Each of CHANNELS channels converts a WIDTH-bit unsigned level into a 1-bit density stream, in either first-order or second-order (error-feedback) mode.
- Levels and control are double-buffered: writes land in shadow registers and reach all channels at once on a commit strobe.
- A shared prescaler sets the modulator update rate; sits between the register/control interface and the output pins.

Parameters:
- WIDTH, 8: level width in bits; 2..16.
- CHANNELS, 4: number of channels; 1..16.
- DIV, 1: modulator step period in clk cycles; 1..65536.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  level write strobe.
- wr_addr  in  max(1,clog2(CHANNELS))  channel index for the level write.
- wr_data  in  WIDTH  level value, unsigned.
- ctrl_wr  in  1  control write strobe.
- ctrl_en  in  CHANNELS  per-channel enable, shadowed.
- ctrl_order2  in  CHANNELS  per-channel mode, shadowed: 1 = second order, 0 = first order.
- commit  in  1  copies all shadow registers to the active registers.
- step  out  1  one-cycle pulse on each modulator step.
- pdm_out  out  CHANNELS  registered density outputs.

Behaviour:
- Reset (reset low, asynchronous) clears all shadow and active levels, enables, modes, integrator/error state, the prescaler, step and pdm_out to 0.
- Shadow writes:
  - wr_en=1 with wr_addr<CHANNELS loads level_sh[wr_addr] <= wr_data.
  - Writes with wr_addr>=CHANNELS are ignored.
  - ctrl_wr=1 loads en_sh <= ctrl_en and ord_sh <= ctrl_order2.
- Commit:
  - On the edge where commit=1, every active register takes its shadow value.
  - If a write and commit occur in the same cycle, the active register takes the newly written value (bypass). Shadow also updates.
- Prescaler:
  - cnt counts 0..DIV-1 and wraps.
  - step_i=1 when cnt==DIV-1. With DIV=1, step_i=1 every cycle.
  - step output is step_i registered, so it is high in the cycle after the edge that updated pdm_out.
- Modulator update happens only on edges where step_i=1. Otherwise all channel state and pdm_out hold.
- Disabled channel (en=0): pdm_out[c]=0; acc, e1 and e2 are held cleared to 0 on every edge (not only step edges).
- First order (ord=0), per step, x = active level:
  - sum = x + acc, computed WIDTH+1 bits wide.
  - pdm_out[c] <= sum[WIDTH]; acc <= sum[WIDTH-1:0].
  - Over 2^WIDTH steps, exactly x ones are produced.
- Second order (ord=1), signed arithmetic at WIDTH+4 bits:
  - v = x + 2*e1 - e2.
  - y = (v >= 2^(WIDTH-1)).
  - e = v - y*2^WIDTH, saturated to [-2^WIDTH, 2^WIDTH-1].
  - pdm_out[c] <= y; e2 <= e1; e1 <= e.
  - acc is unused in this mode.
- Mode change at commit: the first step under the new mode starts from state cleared to 0 (the commit clears acc, e1 and e2 of any channel whose ord changes). A level-only change keeps state.
- Latency:
  - Write + commit at edge n.
  - The new level first affects pdm_out at the first step edge after n.
  - Commit and step in the same cycle: the step uses the old active values.
- Reset asserted mid-stream: all state clears immediately; after release, the first step occurs DIV edges later.

Test Plan:
- WIDTH=8, DIV=1, ch0 first order, level=64, commit: pdm_out[0] reads 0,0,0,1 repeating (first 1 on the 4th step); exactly 64 ones in 256 steps.
- Level 0 -> all zeros; level 255 -> 255 ones per 256 steps; disabled channel with level 128 -> constant 0, and after enable its first bit matches a cold-start model.
- DIV=4: step pulses every 4th cycle; pdm_out changes only on those edges; write level 128 without commit -> output unchanged; commit -> alternating 0,1 pattern begins at the next step.
- Second order, level 96: 4096-step ones count within 1536±2; bit stream matches the reference model exactly; level 0 yields all zeros after 2 steps.
- Same-cycle wr_en (ch2=200) + commit + ctrl_wr: active takes 200 immediately; wr_addr=5 with CHANNELS=4 ignored.
- Assert reset mid-stream at an arbitrary cycle: pdm_out and step go to 0 asynchronously; after release, the first step occurs exactly DIV edges later.
